// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-latched, enable-masked priority interrupt controller (optional nesting: IRQ_NESTING_EN)
module irq_ctrl #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NUM_IRQ-1:0] I_irq_lines,
  input  logic               I_irq_ack,
  input  logic               I_eoi,
  input  logic               I_en_we,
  input  logic [NUM_IRQ-1:0] I_en_data,
  output logic               O_irq_active,
  output logic [15:0]        O_irq_vector,
  output logic [NUM_IRQ-1:0] O_pending,
  output logic [NUM_IRQ-1:0] O_in_service
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_t;

  // Returned for any ack that does not correspond to an offered request.
  localparam logic [15:0] SPURIOUS_VECTOR = VECTOR_BASE + 16'(NUM_IRQ);

  state_t             state;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] prev_lines;
  logic               irq_active;
  logic [15:0]        irq_vector;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] rises;
  logic [3:0]         sel;
  logic               sel_valid;
  logic [NUM_IRQ-1:0] sel_mask;
  logic [NUM_IRQ-1:0] isv_mask;
  logic [NUM_IRQ-1:0] isv_after_eoi;
  logic               ack_take;
  logic               preempt;

  assign eligible = pending & enable;
  assign rises    = I_irq_lines & ~prev_lines;

  // Priority encoders: lowest set index wins, both for requests and for EOI retirement.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    sel_mask  = '0;
    isv_mask  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel         = 4'(i);
        sel_valid   = 1'b1;
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
      if (in_service[i]) begin
        isv_mask    = '0;
        isv_mask[i] = 1'b1;
      end
    end
  end

  // EOI retires the highest-priority active ISR; with nothing in service the mask is zero.
  assign isv_after_eoi = I_eoi ? (in_service & ~isv_mask) : in_service;

  // An ack only counts while a request is actually on offer.
  assign ack_take = (state == ST_REQ) && I_irq_ack && sel_valid;

`ifdef IRQ_NESTING_EN
  logic [3:0] isv_low;

  // Index of the highest-priority source currently in service.
  always_comb begin
    isv_low = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (in_service[i]) isv_low = 4'(i);
    end
  end

  // Only a strictly higher-priority source may interrupt a running ISR.
  assign preempt = sel_valid && (sel < isv_low);
`else
  // Single-level: nothing is offered while any ISR is running.
  assign preempt = 1'b0;
`endif

  // Handshake FSM plus pending/in-service/enable bookkeeping, all registered.
  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      state      <= ST_IDLE;
      pending    <= '0;
      in_service <= '0;
      enable     <= '0;
      prev_lines <= '0;
      irq_active <= 1'b0;
      irq_vector <= SPURIOUS_VECTOR;
    end else begin
      // A new rising edge wins over the ack clearing the same bit.
      pending    <= (pending & ~(ack_take ? sel_mask : '0)) | rises;
      in_service <= isv_after_eoi | (ack_take ? sel_mask : '0);
      prev_lines <= I_irq_lines;
      if (I_en_we) enable <= I_en_data;

      case (state)
        ST_IDLE: begin
          if (I_irq_ack) irq_vector <= SPURIOUS_VECTOR;
          if (sel_valid) begin
            state      <= ST_REQ;
            irq_active <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!sel_valid) begin
            // Request withdrawn (masked) before the ack arrived.
            irq_active <= 1'b0;
            if (I_irq_ack) irq_vector <= SPURIOUS_VECTOR;
            state <= (isv_after_eoi == '0) ? ST_IDLE : ST_SERVICE;
          end else if (I_irq_ack) begin
            irq_vector <= VECTOR_BASE + 16'(sel);
            irq_active <= 1'b0;
            state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (I_irq_ack) irq_vector <= SPURIOUS_VECTOR;
          if (isv_after_eoi == '0) begin
            state <= ST_IDLE;
          end else if (preempt) begin
            state      <= ST_REQ;
            irq_active <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          irq_active <= 1'b0;
        end
      endcase
    end
  end

  assign O_irq_active = irq_active;
  assign O_irq_vector = irq_vector;
  assign O_pending    = pending;
  assign O_in_service = in_service;

endmodule
